// File: rtl/sram_axi_bridge.sv
// ============================================================================
// Module   : sram_axi_bridge
// Purpose  : Merges the CPU instruction and data SRAM-style ports
//            (req / addr_ok / data_ok) into one AXI3-style single-beat master.
//            Each port has at most one transaction outstanding. Read data is
//            steered back to its port by rid.
// Ports    : clk, reset             - clock and asynchronous active-high reset
//            inst_*                 - instruction fetch port (reads only)
//            data_*                 - data load/store port
//            ar* / r*               - AXI read address / read data channels
//            aw* / w* / bvalid      - AXI write address / data / response
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  // instruction port
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // AXI read address / data
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  // AXI write address / data / response
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid
);

  typedef enum logic [0:0] {AR_IDLE = 1'b0, AR_SEND = 1'b1} ar_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_SEND = 2'd1, W_RESP = 2'd2} w_state_t;

  ar_state_t   ar_state_q;
  w_state_t    w_state_q;

  logic        inst_busy_q, data_busy_q;
  logic        inst_data_ok_q, data_data_ok_q;
  logic [31:0] inst_rdata_q, data_rdata_q;

  logic        arvalid_q;
  logic [3:0]  arid_q;
  logic [31:0] araddr_q;
  logic [2:0]  arsize_q;

  logic        awvalid_q, wvalid_q;
  logic [31:0] awaddr_q, wdata_q;
  logic [2:0]  awsize_q;
  logic [3:0]  wstrb_q;

  // ---------------------------------------------------------------- acceptance
  logic ar_idle, w_idle;
  logic data_rd_acc, data_wr_acc, inst_acc;

  assign ar_idle = (ar_state_q == AR_IDLE);
  assign w_idle  = (w_state_q == W_IDLE);

  // A load also waits for W_IDLE so it can never overtake a pending store.
  assign data_rd_acc = data_req && !data_wr && ar_idle && !data_busy_q && w_idle;
  assign data_wr_acc = data_req &&  data_wr && w_idle  && !data_busy_q;
  // A simultaneous data load owns the AR channel this cycle.
  assign inst_acc    = inst_req && ar_idle && !inst_busy_q && !data_rd_acc;

  assign data_addr_ok = data_rd_acc || data_wr_acc;
  assign inst_addr_ok = inst_acc;

  // ---------------------------------------------------------------- responses
  logic inst_hit, data_rd_hit, data_wr_hit;
  logic inst_busy_d, data_busy_d;

  assign inst_hit    = rvalid && (rid == INST_ID);
  assign data_rd_hit = rvalid && (rid == DATA_ID);
  assign data_wr_hit = (w_state_q == W_RESP) && bvalid;

  // Completion and acceptance never overlap on one port (acceptance needs
  // !busy), so a completing port is free again one edge later.
  assign inst_busy_d = inst_acc ? 1'b1 : (inst_hit ? 1'b0 : inst_busy_q);
  assign data_busy_d = data_addr_ok ? 1'b1
                     : ((data_rd_hit || data_wr_hit) ? 1'b0 : data_busy_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_busy_q    <= 1'b0;
      data_busy_q    <= 1'b0;
      inst_data_ok_q <= 1'b0;
      data_data_ok_q <= 1'b0;
      inst_rdata_q   <= 32'd0;
      data_rdata_q   <= 32'd0;
    end else begin
      inst_busy_q    <= inst_busy_d;
      data_busy_q    <= data_busy_d;
      inst_data_ok_q <= inst_hit;
      data_data_ok_q <= data_rd_hit || data_wr_hit;
      if (inst_hit)    inst_rdata_q <= rdata;
      if (data_rd_hit) data_rdata_q <= rdata;
    end
  end

  // ---------------------------------------------------------------- AR FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ar_state_q <= AR_IDLE;
      arvalid_q  <= 1'b0;
      arid_q     <= 4'd0;
      araddr_q   <= 32'd0;
      arsize_q   <= 3'd0;
    end else begin
      case (ar_state_q)
        AR_IDLE: begin
          if (data_rd_acc) begin
            ar_state_q <= AR_SEND;
            arvalid_q  <= 1'b1;
            arid_q     <= DATA_ID;
            araddr_q   <= data_addr;
            arsize_q   <= {1'b0, data_size};
          end else if (inst_acc) begin
            ar_state_q <= AR_SEND;
            arvalid_q  <= 1'b1;
            arid_q     <= INST_ID;
            araddr_q   <= inst_addr;
            arsize_q   <= 3'd2;
          end
        end
        AR_SEND: begin
          if (arready) begin
            ar_state_q <= AR_IDLE;
            arvalid_q  <= 1'b0;
          end
        end
        default: begin
          ar_state_q <= AR_IDLE;
          arvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- W FSM
  // A channel counts as done if its valid already dropped or it handshakes now.
  logic aw_done, w_done;
  assign aw_done = !awvalid_q || awready;
  assign w_done  = !wvalid_q  || wready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awaddr_q  <= 32'd0;
      awsize_q  <= 3'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (data_wr_acc) begin
            w_state_q <= W_SEND;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            awaddr_q  <= data_addr;
            awsize_q  <= {1'b0, data_size};
            wdata_q   <= data_wdata;
            wstrb_q   <= data_wstrb;
          end
        end
        W_SEND: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) w_state_q <= W_RESP;
        end
        W_RESP: begin
          if (bvalid) w_state_q <= W_IDLE;
        end
        default: begin
          w_state_q <= W_IDLE;
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  assign inst_data_ok = inst_data_ok_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_data_ok = data_data_ok_q;
  assign data_rdata   = data_rdata_q;

  assign arvalid = arvalid_q;
  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;

  assign awvalid = awvalid_q;
  assign awaddr  = awaddr_q;
  assign awsize  = awsize_q;
  assign wvalid  = wvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_axi_bridge.sv
// ============================================================================
// Module   : tb_sram_axi_bridge
// Purpose  : Directed self-checking bench for sram_axi_bridge. The bench plays
//            the CPU and the AXI slave; expected values are hand-computed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready, bvalid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sram_axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .bvalid(bvalid)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 ns after it; inputs change here, well away
  // from the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;

    // ---------------- reset state
    tick(); tick();
    check_val("rst_arvalid",  {31'd0, arvalid},  32'd0);
    check_val("rst_awvalid",  {31'd0, awvalid},  32'd0);
    check_val("rst_wvalid",   {31'd0, wvalid},   32'd0);
    check_val("rst_inst_ok",  {31'd0, inst_data_ok}, 32'd0);
    check_val("rst_data_ok",  {31'd0, data_data_ok}, 32'd0);
    check_val("rst_inst_rd",  inst_rdata, 32'd0);
    check_val("rst_data_rd",  data_rdata, 32'd0);
    reset = 1'b0;
    tick();

    // ---------------- single fetch
    inst_req = 1; inst_addr = 32'h1C00_0000;
    #1 check_val("f_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    tick();
    inst_req = 0;
    check_val("f_arvalid", {31'd0, arvalid}, 32'd1);
    check_val("f_arid",    {28'd0, arid},    32'd0);
    check_val("f_araddr",  araddr,           32'h1C00_0000);
    check_val("f_arsize",  {29'd0, arsize},  32'd2);
    arready = 1;
    tick();
    arready = 0;
    check_val("f_ar_drop", {31'd0, arvalid}, 32'd0);
    rvalid = 1; rid = 4'd0; rdata = 32'h0280_0C0C;
    tick();
    rvalid = 0;
    check_val("f_data_ok", {31'd0, inst_data_ok}, 32'd1);
    check_val("f_rdata",   inst_rdata, 32'h0280_0C0C);
    // Unknown rid must be ignored by both ports.
    rvalid = 1; rid = 4'd5; rdata = 32'hFFFF_FFFF;
    tick();
    rvalid = 0;
    check_val("badid_inst_ok", {31'd0, inst_data_ok}, 32'd0);
    check_val("badid_data_ok", {31'd0, data_data_ok}, 32'd0);
    check_val("badid_inst_rd", inst_rdata, 32'h0280_0C0C);

    // ---------------- contention: data load beats fetch
    inst_req = 1; inst_addr = 32'h1C00_0010;
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h0000_1000;
    #1;
    check_val("c_data_ok", {31'd0, data_addr_ok}, 32'd1);
    check_val("c_inst_ok", {31'd0, inst_addr_ok}, 32'd0);
    tick();
    data_req = 0;
    check_val("c_arid1",   {28'd0, arid}, 32'd1);
    check_val("c_araddr1", araddr, 32'h0000_1000);
    #1 check_val("c_inst_wait", {31'd0, inst_addr_ok}, 32'd0);
    arready = 1;
    tick();
    arready = 0;
    #1 check_val("c_inst_acc", {31'd0, inst_addr_ok}, 32'd1);
    tick();
    inst_req = 0;
    check_val("c_arid0",   {28'd0, arid}, 32'd0);
    check_val("c_araddr0", araddr, 32'h1C00_0010);
    arready = 1;
    tick();
    arready = 0;
    rvalid = 1; rid = 4'd0; rdata = 32'h1111_2222;
    tick();
    check_val("c_i_ok",   {31'd0, inst_data_ok}, 32'd1);
    check_val("c_i_rd",   inst_rdata, 32'h1111_2222);
    check_val("c_d_quiet",{31'd0, data_data_ok}, 32'd0);
    rid = 4'd1; rdata = 32'h3333_4444;
    tick();
    rvalid = 0;
    check_val("c_d_ok",   {31'd0, data_data_ok}, 32'd1);
    check_val("c_d_rd",   data_rdata, 32'h3333_4444);
    check_val("c_i_quiet",{31'd0, inst_data_ok}, 32'd0);
    tick();

    // ---------------- byte store, wready immediate, awready late
    data_req = 1; data_wr = 1; data_size = 0; data_wstrb = 4'b0100;
    data_addr = 32'h0000_2002; data_wdata = 32'h00AB_0000;
    wready = 1;
    #1 check_val("s_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    tick();
    // cycle 1 of W_SEND; a load arrives and must be refused
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h0000_3000;
    check_val("s_awvalid1", {31'd0, awvalid}, 32'd1);
    check_val("s_wvalid1",  {31'd0, wvalid},  32'd1);
    check_val("s_awsize",   {29'd0, awsize},  32'd0);
    check_val("s_awaddr",   awaddr, 32'h0000_2002);
    check_val("s_wdata",    wdata,  32'h00AB_0000);
    check_val("s_wstrb",    {28'd0, wstrb}, 32'h4);
    #1 check_val("s_load_blk", {31'd0, data_addr_ok}, 32'd0);
    tick();
    wready = 0;
    check_val("s_wvalid2",  {31'd0, wvalid},  32'd0);
    check_val("s_awvalid2", {31'd0, awvalid}, 32'd1);
    #1 check_val("s_load_blk2", {31'd0, data_addr_ok}, 32'd0);
    tick();
    check_val("s_awvalid3", {31'd0, awvalid}, 32'd1);
    tick();
    check_val("s_awvalid4", {31'd0, awvalid}, 32'd1);
    awready = 1;
    tick();
    awready = 0;
    check_val("s_aw_drop", {31'd0, awvalid}, 32'd0);
    check_val("s_no_ok",   {31'd0, data_data_ok}, 32'd0);
    bvalid = 1;
    tick();
    bvalid = 0;
    check_val("s_data_ok", {31'd0, data_data_ok}, 32'd1);
    // back-to-back: the held load is accepted in the data_ok cycle
    #1 check_val("b2b_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    tick();
    data_req = 0;
    check_val("b2b_arvalid", {31'd0, arvalid}, 32'd1);
    check_val("b2b_arid",    {28'd0, arid},    32'd1);
    check_val("b2b_araddr",  araddr, 32'h0000_3000);
    check_val("b2b_ok_pulse",{31'd0, data_data_ok}, 32'd0);
    arready = 1;
    tick();
    arready = 0;
    rvalid = 1; rid = 4'd1; rdata = 32'h5555_6666;
    tick();
    rvalid = 0;
    check_val("b2b_rd", data_rdata, 32'h5555_6666);
    tick();

    // ---------------- reset mid-flight
    inst_req = 1; inst_addr = 32'h1C00_0004;
    data_req = 1; data_wr = 1; data_size = 2; data_wstrb = 4'hF;
    data_addr = 32'h0000_4000; data_wdata = 32'hDEAD_BEEF;
    #1;
    check_val("r_inst_acc", {31'd0, inst_addr_ok}, 32'd1);
    check_val("r_data_acc", {31'd0, data_addr_ok}, 32'd1);
    tick();
    inst_req = 0; data_req = 0;
    check_val("r_arvalid_pre", {31'd0, arvalid}, 32'd1);
    check_val("r_awvalid_pre", {31'd0, awvalid}, 32'd1);
    reset = 1;
    #1;
    check_val("r_arvalid", {31'd0, arvalid}, 32'd0);
    check_val("r_awvalid", {31'd0, awvalid}, 32'd0);
    check_val("r_wvalid",  {31'd0, wvalid},  32'd0);
    check_val("r_oks", {28'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'd0);
    check_val("r_rdata", data_rdata, 32'd0);
    tick();
    reset = 0;
    tick();
    inst_req = 1; inst_addr = 32'h1C00_0008;
    #1 check_val("r_f_ok", {31'd0, inst_addr_ok}, 32'd1);
    tick();
    inst_req = 0;
    check_val("r_f_araddr", araddr, 32'h1C00_0008);
    arready = 1;
    tick();
    arready = 0;
    rvalid = 1; rid = 4'd0; rdata = 32'hCAFE_F00D;
    tick();
    rvalid = 0;
    check_val("r_f_data_ok", {31'd0, inst_data_ok}, 32'd1);
    check_val("r_f_rdata",   inst_rdata, 32'hCAFE_F00D);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_axi_bridge.md
Name:
sram_axi_bridge

Overview:
Sits directly downstream of the CPU core's instruction and data memory ports and converts them to a single AXI3-style master. Both memory ports use a req/addr_ok/data_ok handshake. Each port allows at most one outstanding transaction; the AXI ID field steers read data back to the correct port.

Parameters:
INST_ID, 4'd0, arid used for instruction fetches; matched against rid.
DATA_ID, 4'd1, arid used for data loads; matched against rid. All writes use DATA_ID; top level ties awid to it.

Ports:
clk  input  1  clock; everything is rising-edge.
reset  input  1  asynchronous, active-high reset.
inst_req  input  1  fetch request valid.
inst_addr  input  32  fetch address; size is always 4 bytes.
inst_addr_ok  output  1  request accepted this cycle (combinational).
inst_data_ok  output  1  one-cycle pulse: inst_rdata is valid.
inst_rdata  output  32  fetch data (registered).
data_req  input  1  load/store request valid.
data_wr  input  1  1 = store, 0 = load.
data_size  input  2  0 = byte, 1 = half, 2 = word.
data_wstrb  input  4  byte enables for a store.
data_addr  input  32  load/store address.
data_wdata  input  32  store data.
data_addr_ok  output  1  request accepted this cycle (combinational).
data_data_ok  output  1  one-cycle pulse: load data valid, or store completed.
data_rdata  output  32  load data (registered).
arid  output  4  read ID.
araddr  output  32  read address.
arsize  output  3  read size, {1'b0,size}.
arvalid  output  1  read-address valid.
arready  input  1  read-address ready.
rid  input  4  read-response ID.
rdata  input  32  read data.
rvalid  input  1  read data valid; rready is tied 1 at top (bridge always accepts).
awaddr  output  32  write address.
awsize  output  3  write size, {1'b0,data_size}.
awvalid  output  1  write-address valid.
awready  input  1  write-address ready.
wdata  output  32  write data.
wstrb  output  4  write strobes.
wvalid  output  1  write data valid.
wready  input  1  write data ready.
bvalid  input  1  write response valid; bready is tied 1 at top, bresp ignored.

Behaviour:
- Reset (asynchronous):
  - All valid, addr_ok and data_ok outputs go to 0; inst_rdata and data_rdata go to 0.
  - inst_busy and data_busy flags clear; the AR FSM goes to AR_IDLE and the W FSM to W_IDLE.
  - Any AXI transaction in flight is abandoned; the slave is reset together with the bridge.
- Single-beat only: len is 0 and burst is INCR, both tied at top. Addresses pass through unaligned exactly as given.
- AR FSM: AR_IDLE -> AR_SEND on accepting a read; AR_SEND -> AR_IDLE in the cycle arvalid && arready.
  - arvalid, arid, araddr and arsize are registered at acceptance and held stable until arready.
- Read acceptance (combinational):
  - data_addr_ok = data_req && !data_wr && AR_IDLE && !data_busy && W_IDLE.
  - inst_addr_ok = inst_req && AR_IDLE && !inst_busy && !(data read wins).
  - A data read has priority over an inst read in the same cycle.
  - Acceptance sets the port's busy flag; inst reads drive arsize = 2.
- Store acceptance: data_addr_ok = data_req && data_wr && W_IDLE && !data_busy.
  - W FSM: W_IDLE -> W_SEND (awvalid and wvalid both 1 the next cycle). Each valid drops independently in its own ready cycle.
  - When both handshakes are done: -> W_RESP. On bvalid -> W_IDLE, data_data_ok pulses the next cycle, and data_busy clears.
- Read return: on rvalid, rid is matched against the port IDs.
  - rid == INST_ID: inst_rdata <= rdata, inst_data_ok = 1 the next cycle, inst_busy clears.
  - rid == DATA_ID: the same for the data port.
  - Any other rid is ignored.
- busy clears in the same edge that raises data_ok, so a new addr_ok may coincide with data_ok. Responses may return out of order across the two ports.
- The data port has a single outstanding transaction in total (load or store), so a data load never overtakes a pending store.

Test Plan:
- Fetch: inst_req with inst_addr = 0x1C000000 -> inst_addr_ok = 1 in the same cycle. Next cycle arvalid = 1, arid = 0, araddr = 0x1C000000, arsize = 2. Slave returns rid = 0, rdata = 0x02800C0C -> one cycle later inst_data_ok = 1 and inst_rdata = 0x02800C0C.
- Contention: inst_req and data load (addr 0x00001000) in the same cycle -> data_addr_ok = 1 and inst_addr_ok = 0; arid = 1 is issued first and inst is accepted after arready. Slave answers rid 0 before rid 1 -> each port's data_ok and rdata are correct.
- Byte store: data_wr = 1, size 0, wstrb 4'b0100, addr 0x00002002, wdata 0x00AB0000; wready immediate, awready delayed 3 cycles.
  - wvalid drops after 1 cycle; awvalid is held 4 cycles with awsize = 0.
  - A data load arriving meanwhile gets data_addr_ok = 0.
  - bvalid -> data_data_ok one cycle later.
- Back-to-back: a new data_req is held during the data_data_ok cycle -> data_addr_ok = 1 in that same cycle.
- Reset mid-flight: reset asserted while arvalid = 1 and awvalid = 1 -> both drop to 0 immediately, all ok outputs 0. After release a fresh fetch completes normally.
